// File: rtl/mixcolumns_serial.sv
// Column-serial AES MixColumns stage: accepts one 128-bit state, transforms
// COLS_PER_CYCLE columns per cycle in place, then holds the result until taken.
module mixcolumns_serial #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mixcolumns_serial: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // For COLS_PER_CYCLE=4 the step truncates to 0; the counter then stays at 0.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);
  localparam logic [2:0] SPAN = 3'(COLS_PER_CYCLE);

  state_t         state;
  logic [127:0]   work;
  logic [127:0]   next_work;
  logic [1:0]     cnt;
  logic           bypass;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Working-register update: transform the columns in the current group.
  always_comb begin
    next_work = work;
    for (int c = 0; c < 4; c++) begin
      if (!bypass && (3'(c) >= {1'b0, cnt}) && (3'(c) < ({1'b0, cnt} + SPAN))) begin
        next_work[127-32*c -: 32] = mix_col(work[127-32*c -: 32]);
      end else begin
        next_work[127-32*c -: 32] = work[127-32*c -: 32];
      end
    end
  end

  // Control FSM, column counter, bypass flag and working register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= 128'h0;
      cnt    <= 2'd0;
      bypass <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work   <= in_data;
            bypass <= in_bypass;
            cnt    <= 2'd0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          work <= next_work;
          cnt  <= cnt + STEP;
          if (cnt == LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              work   <= in_data;
              bypass <= in_bypass;
              cnt    <= 2'd0;
              state  <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign out_data  = work;
  // Only combinational input-to-output path: lets a back-to-back accept overlap DONE.
  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);

endmodule
